// File: rtl/flux_pkg.sv
// Shared types and helpers for the spectral flux detector.
// Contents:
//   state_t       : detector mode (IDLE -> CALIB -> RUN)
//   flux_w        : width holding NUM_BINS worth of full-scale magnitudes
//   hist_w        : width holding HIST_LEN flux values
//   sat_mul_shift : (val * num) >> shift, clamped to out_w bits
package flux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALIB = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int flux_w(input int mag_w, input int num_bins);
    return mag_w + $clog2(num_bins);
  endfunction

  function automatic int hist_w(input int fw, input int hist_len);
    return fw + $clog2(hist_len);
  endfunction

  function automatic logic [63:0] sat_mul_shift(input logic [63:0] val, input int num,
                                                input int shift, input int out_w);
    logic [63:0] prod;
    logic [63:0] lim;
    prod = (val * 64'(num)) >> shift;
    lim  = (64'd1 << out_w) - 64'd1;
    return (prod > lim) ? lim : prod;
  endfunction

endpackage

// File: rtl/flux_prev_ram.sv
// Previous-frame magnitude store: simple dual-port RAM with synchronous read.
// A read and write to the same address in one cycle returns the old contents.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr     read port, data on o_rdata the following cycle
module flux_prev_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/spectral_flux_detector.sv
// Spectral flux beat detector. Takes a bin-serial FFT magnitude stream,
// computes half-wave-rectified flux over bins BIN_LO..BIN_HI per frame, and
// flags a beat when flux beats an adaptive threshold (scaled mean of the last
// HIST_LEN fluxes) and FLUX_MIN, outside a refractory window.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_start                  leave IDLE and start calibration
//   o_finish                 high while in RUN
//   i_mag_valid/data/last    magnitude stream. Handshake: a sample transfers on
//                            every clock i_mag_valid is high; there is no ready,
//                            the source never stalls; i_mag_last marks frame end.
//   o_flux, o_thresh         flux and threshold of the last completed frame
//   o_flux_valid             one-cycle pulse per completed frame
//   o_beat                   one-cycle beat pulse (coincides with o_flux_valid)
//   o_frame_err              one-cycle pulse: frame length was not NUM_BINS
module spectral_flux_detector import flux_pkg::*; #(
  parameter int MAG_W        = 16,
  parameter int NUM_BINS     = 256,
  parameter int BIN_LO       = 2,
  parameter int BIN_HI       = 64,
  parameter int HIST_LEN     = 8,
  parameter int THRESH_NUM   = 3,
  parameter int THRESH_SHIFT = 1,
  parameter int FLUX_MIN     = 1000,
  parameter int REFRACT_CYC  = 4000000,
  parameter int CALIB_FRAMES = 16,
  localparam int FLUX_W      = flux_w(MAG_W, NUM_BINS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_finish,
  input  logic              i_mag_valid,
  input  logic [MAG_W-1:0]  i_mag_data,
  input  logic              i_mag_last,
  output logic [FLUX_W-1:0] o_flux,
  output logic              o_flux_valid,
  output logic [FLUX_W-1:0] o_thresh,
  output logic              o_beat,
  output logic              o_frame_err
);

  localparam int BIN_W  = $clog2(NUM_BINS);
  localparam int CNT_W  = BIN_W + 1;
  localparam int HIST_W = hist_w(FLUX_W, HIST_LEN);
  localparam int HL_LOG = $clog2(HIST_LEN);
  localparam int RF_W   = $clog2(REFRACT_CYC + 1);
  localparam int CC_W   = $clog2(CALIB_FRAMES + 1);

  state_t state_q, state_d;
  logic   enter_calib;

  // S1: sample capture and prev RAM access
  logic [CNT_W-1:0] bin_cnt_q;
  logic             first_q;
  logic             accept, in_range, in_band;
  logic             s1_valid_q, s1_last_q, s1_use_q, s1_err_q;
  logic [MAG_W-1:0] s1_cur_q, prev_rd;

  // S2: rectified diff accumulation
  logic [MAG_W-1:0]  diff;
  logic [FLUX_W-1:0] acc_q, acc_sum, flux_q;
  logic              s2_valid_q, s2_err_q;

  // S3: evaluation
  logic [FLUX_W-1:0] hist_q [HIST_LEN];
  logic [HL_LOG-1:0] hptr_q;
  logic [HIST_W-1:0] hsum_q;
  logic [CC_W-1:0]   calib_cnt_q;
  logic [RF_W-1:0]   refract_q;
  logic [FLUX_W-1:0] thresh_d, flux_o_q, thresh_o_q;
  logic              beat_d, fv_q, beat_q, err_q;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    enter_calib = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d     = CALIB;
          enter_calib = 1'b1;
        end
      end
      CALIB: begin
        if (s2_valid_q && calib_cnt_q == CC_W'(CALIB_FRAMES - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign o_finish = (state_q == RUN);

  // ---------------- S1 ----------------
  assign accept   = i_mag_valid && (state_q != IDLE);
  // Counter saturates at NUM_BINS so overlong frames stop touching the RAM.
  assign in_range = bin_cnt_q < CNT_W'(NUM_BINS);
  assign in_band  = (bin_cnt_q >= CNT_W'(BIN_LO)) && (bin_cnt_q <= CNT_W'(BIN_HI));

  flux_prev_ram #(.DEPTH(NUM_BINS), .WIDTH(MAG_W)) u_prev_ram (
    .i_clk   (i_clk),
    .i_we    (accept && in_range),
    .i_waddr (bin_cnt_q[BIN_W-1:0]),
    .i_wdata (i_mag_data),
    .i_re    (accept && in_range),
    .i_raddr (bin_cnt_q[BIN_W-1:0]),
    .o_rdata (prev_rd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bin_cnt_q  <= '0;
      first_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_use_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_cur_q   <= '0;
    end else begin
      if (enter_calib) first_q <= 1'b1;
      if (accept) begin
        if (i_mag_last) begin
          bin_cnt_q <= '0;
          first_q   <= 1'b0;
        end else if (in_range) begin
          bin_cnt_q <= bin_cnt_q + 1'b1;
        end
      end
      s1_valid_q <= accept;
      s1_last_q  <= accept && i_mag_last;
      // The first frame only primes the RAM, so its diffs are forced to zero.
      s1_use_q   <= in_range && in_band && !first_q;
      s1_err_q   <= (bin_cnt_q != CNT_W'(NUM_BINS - 1));
      s1_cur_q   <= i_mag_data;
    end
  end

  // ---------------- S2 ----------------
  assign diff    = (s1_cur_q > prev_rd) ? (s1_cur_q - prev_rd) : '0;
  assign acc_sum = acc_q + (s1_use_q ? FLUX_W'(diff) : '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q      <= '0;
      flux_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          flux_q   <= acc_sum;
          acc_q    <= '0;
          s2_err_q <= s1_err_q;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  // ---------------- S3: evaluate ----------------
  assign thresh_d = FLUX_W'(sat_mul_shift(64'(hsum_q >> HL_LOG), THRESH_NUM, THRESH_SHIFT, FLUX_W));
  assign beat_d   = (state_q == RUN) && (flux_q > thresh_d) &&
                    (flux_q >= FLUX_W'(FLUX_MIN)) && (refract_q == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < HIST_LEN; i++) hist_q[i] <= '0;
      hptr_q      <= '0;
      hsum_q      <= '0;
      calib_cnt_q <= '0;
      refract_q   <= '0;
      flux_o_q    <= '0;
      thresh_o_q  <= '0;
      fv_q        <= 1'b0;
      beat_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fv_q   <= s2_valid_q;
      beat_q <= s2_valid_q && beat_d;
      err_q  <= s2_valid_q && s2_err_q;
      if (enter_calib) begin
        for (int i = 0; i < HIST_LEN; i++) hist_q[i] <= '0;
        hptr_q      <= '0;
        hsum_q      <= '0;
        calib_cnt_q <= '0;
      end else if (s2_valid_q) begin
        flux_o_q       <= flux_q;
        thresh_o_q     <= thresh_d;
        // Threshold above uses the history before this frame is pushed.
        hist_q[hptr_q] <= flux_q;
        hsum_q         <= hsum_q + HIST_W'(flux_q) - HIST_W'(hist_q[hptr_q]);
        hptr_q         <= hptr_q + 1'b1;
        if (state_q == CALIB) calib_cnt_q <= calib_cnt_q + 1'b1;
      end
      if (s2_valid_q && beat_d) refract_q <= RF_W'(REFRACT_CYC);
      else if (refract_q != '0) refract_q <= refract_q - 1'b1;
    end
  end

  assign o_flux       = flux_o_q;
  assign o_thresh     = thresh_o_q;
  assign o_flux_valid = fv_q;
  assign o_beat       = beat_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_spectral_flux_detector.sv
// Bench for spectral_flux_detector: directed scenarios with literal
// expectations plus randomized frames, all checked against a frame-level model.
module tb_spectral_flux_detector;

  localparam int MAG_W    = 16;
  localparam int NUM_BINS = 256;
  localparam int FLUX_W   = 24;
  localparam int REFRACT  = 1000;
  localparam int CALIB    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, mag_valid, mag_last;
  logic [MAG_W-1:0]  mag_data;
  logic              finish, flux_valid, beat, frame_err;
  logic [FLUX_W-1:0] flux, thresh;

  spectral_flux_detector #(.REFRACT_CYC(REFRACT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_finish     (finish),
    .i_mag_valid  (mag_valid),
    .i_mag_data   (mag_data),
    .i_mag_last   (mag_last),
    .o_flux       (flux),
    .o_flux_valid (flux_valid),
    .o_thresh     (thresh),
    .o_beat       (beat),
    .o_frame_err  (frame_err)
  );

  longint cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  int      fbuf [300];
  int      prev_m [NUM_BINS];
  bit      first_m;
  longint  hist_m [8];
  int      hptr_m;
  bit      run_m;
  int      calib_m;
  longint  last_beat;
  bit      chk_en;
  logic [FLUX_W:0] exp_q [$];   // {frame_err, flux}

  typedef struct {longint f; longint t; bit b; bit e;} obs_t;
  obs_t obs_q [$];

  task automatic model_clear();
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 8; i++) hist_m[i] = 0;
    hptr_m    = 0;
    run_m     = 0;
    calib_m   = 0;
    first_m   = 0;
    last_beat = -1000000000;
  endtask

  // Flux of the frame in fbuf[0..n-1] against the previous frame's bins.
  task automatic model_frame(input int n);
    longint f = 0;
    int m = (n < NUM_BINS) ? n : NUM_BINS;
    for (int i = 0; i < m; i++) begin
      if (!first_m && i >= 2 && i <= 64 && fbuf[i] > prev_m[i]) f += fbuf[i] - prev_m[i];
      prev_m[i] = fbuf[i];
    end
    first_m = 0;
    exp_q.push_back({(n != NUM_BINS), FLUX_W'(f)});
  endtask

  // ---------------- scoreboard ----------------
  logic [FLUX_W:0] e;
  longint          sum_m, thr_m, ef_m;
  bit              eb_m;

  always @(negedge clk) begin
    if (chk_en) begin
      if (flux_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_flux_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e     = exp_q.pop_front();
          ef_m  = longint'(e[FLUX_W-1:0]);
          sum_m = 0;
          for (int i = 0; i < 8; i++) sum_m += hist_m[i];
          thr_m = ((sum_m / 8) * 3) / 2;
          if (thr_m > 64'd16777215) thr_m = 16777215;
          eb_m  = run_m && (ef_m > thr_m) && (ef_m >= 1000) && (cyc - last_beat > REFRACT);
          check("flux", flux, ef_m);
          check("thresh", thresh, thr_m);
          check("beat", beat, eb_m);
          check("frame_err", frame_err, e[FLUX_W]);
          if (eb_m) last_beat = cyc;
          hist_m[hptr_m] = ef_m;
          hptr_m = (hptr_m + 1) % 8;
          if (!run_m) begin
            calib_m++;
            if (calib_m == CALIB) run_m = 1;
          end
          obs_q.push_back('{flux, thresh, beat, frame_err});
        end
      end else begin
        check("beat_idle", beat, 0);
        check("frame_err_idle", frame_err, 0);
      end
      check("finish", finish, run_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill(input int base);
    for (int i = 0; i < 300; i++) fbuf[i] = base;
  endtask

  task automatic band(input int lo, input int hi, input int val);
    for (int i = lo; i <= hi; i++) fbuf[i] = val;
  endtask

  task automatic send_frame(input int n, input int gap, input bit bubbles);
    model_frame(n);
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 7) == 0) begin
        mag_valid = 1'b0;
        mag_last  = 1'b0;
        @(posedge clk); #1;
      end
      mag_valid = 1'b1;
      mag_data  = MAG_W'(fbuf[i]);
      mag_last  = (i == n - 1);
      @(posedge clk); #1;
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Drives samples without any model expectation (dropped or discarded data).
  task automatic drive_raw(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      mag_valid = 1'b1;
      mag_data  = 16'd100;
      mag_last  = with_last && (i == n - 1);
      @(posedge clk); #1;
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
  endtask

  task automatic do_start();
    for (int i = 0; i < 8; i++) hist_m[i] = 0;
    hptr_m  = 0;
    calib_m = 0;
    first_m = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_flux_valid"}, flux_valid, 0);
    check({tag, "_beat"}, beat, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_flux"}, flux, 0);
    check({tag, "_thresh"}, thresh, 0);
  endtask

  task automatic do_reset();
    chk_en    = 0;
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    model_clear();
    chk_en = 1;
  endtask

  // Pops the next observed evaluation and pins it to literal values (-1 skips).
  task automatic expect_eval(input string name, input longint f, input longint t,
                             input int b, input int er);
    obs_t o;
    int w = 0;
    while (obs_q.size() == 0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    if (obs_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no evaluation expected one", name);
    end else begin
      o = obs_q.pop_front();
      check({name, "_flux"}, o.f, f);
      if (t >= 0) check({name, "_thresh"}, o.t, t);
      if (b >= 0) check({name, "_beat"}, o.b, b);
      check({name, "_err"}, o.e, er);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; mag_valid = 1'b0; mag_data = '0; mag_last = 1'b0;
    chk_en = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("por");
    rst_n = 1'b1;
    chk_en = 1;

    // Samples in IDLE are dropped: no evaluation may appear.
    drive_raw(20, 1);
    repeat (6) begin @(posedge clk); #1; end

    // Reset in the middle of a frame.
    do_start();
    drive_raw(50, 0);
    do_reset();

    // Calibration: 16 flat frames, flux 0, no beats, finish on the 16th.
    do_start();
    fill(100);
    for (int k = 0; k < CALIB; k++) begin
      send_frame(NUM_BINS, 2, 0);
      expect_eval("calib", 0, 0, 0, 0);
      if (k == CALIB - 2) check("finish_before_last_calib", finish, 0);
    end
    check("finish_after_calib", finish, 1);

    // Onset with zero history.
    fill(100); band(2, 64, 150);
    send_frame(NUM_BINS, 2, 0);
    expect_eval("onset", 3150, 0, 1, 0);

    // Back down, then a second spike inside the refractory window.
    fill(100);
    send_frame(NUM_BINS, 2, 0);
    expect_eval("down", 0, 589, 0, 0);
    fill(100); band(2, 64, 150);
    send_frame(NUM_BINS, 2, 0);
    expect_eval("refract_hold", 3150, 589, 0, 0);

    // Let the refractory window expire, then spike again.
    repeat (1100) begin @(posedge clk); #1; end
    fill(100);
    send_frame(NUM_BINS, 2, 0);
    expect_eval("base", 0, -1, 0, 0);
    fill(100); band(2, 64, 150);
    send_frame(NUM_BINS, 2, 0);
    expect_eval("refract_expired", 3150, 1180, 1, 0);

    // Rectification and band limits.
    fill(100); fbuf[100] = 1100;
    send_frame(NUM_BINS, 2, 0);
    expect_eval("out_of_band", 0, -1, 0, 0);
    fill(100); band(2, 64, 50);
    send_frame(NUM_BINS, 2, 0);
    expect_eval("decrease", 0, -1, 0, 0);

    // Short frame followed back-to-back by a full one.
    fill(100);
    send_frame(100, 0, 0);
    fill(100); band(2, 64, 120);
    send_frame(NUM_BINS, 4, 0);
    expect_eval("short_frame", 3150, -1, -1, 1);
    expect_eval("b2b_frame", 1260, -1, -1, 0);

    // Randomized frames: random data, lengths, gaps and valid bubbles.
    for (int k = 0; k < 24; k++) begin
      int r, n;
      r = $urandom_range(0, 9);
      n = (r == 0) ? $urandom_range(200, 255) : (r == 1) ? $urandom_range(257, 290) : NUM_BINS;
      for (int i = 0; i < 300; i++) fbuf[i] = $urandom_range(0, 3000);
      send_frame(n, $urandom_range(0, 3), 1);
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(200, 1200)) begin @(posedge clk); #1; end
      obs_q.delete();
    end

    // Drain outstanding evaluations.
    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(negedge clk);
    check("pending_evaluations", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
